// File: rtl/tmr_vote_pkg.sv
// Shared definitions for the TMR voting boundary: replica indices, run-counter
// width and a bitwise majority helper for checker code.
package tmr_vote_pkg;

  localparam int REP_A     = 0;
  localparam int REP_B     = 1;
  localparam int REP_C     = 2;
  localparam int NUM_REP   = 3;
  localparam int RUN_CNT_W = 4;

  typedef logic [RUN_CNT_W-1:0] runCnt_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/majority_voter.sv
// Combinational bitwise 2-of-3 voter; reports which replicas differ from the
// voted word so any TMR boundary stage can reuse it.
module majority_voter
  import tmr_vote_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic [WIDTH-1:0] inC,
  output logic [WIDTH-1:0] voted,
  output logic [2:0]       disagree
);

  // vote and per-replica disagreement
  always_comb begin
    voted             = (inA & inB) | (inA & inC) | (inB & inC);
    disagree          = 3'b000;
    disagree[REP_A]   = |(inA ^ voted);
    disagree[REP_B]   = |(inB ^ voted);
    disagree[REP_C]   = |(inC ^ voted);
  end

endmodule

// File: rtl/tmr_vote_reg.sv
// Two-stage registered TMR voter with per-replica fault detection.
// Optional saturating error counter enabled by defining TMR_VOTE_ERRCNT_EN.
module tmr_vote_reg
  import tmr_vote_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int FAULT_THRESH = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     inA,
  input  logic [WIDTH-1:0]     inB,
  input  logic [WIDTH-1:0]     inC,
  input  logic                 valid_i,
  input  logic                 clear_i,
  output logic [WIDTH-1:0]     out_o,
  output logic                 valid_o,
  output logic                 err_o,
  output logic [2:0]           fault_o,
  output logic [CNT_WIDTH-1:0] err_count_o
);

  localparam runCnt_t THRESH = RUN_CNT_W'(FAULT_THRESH);

  logic [WIDTH-1:0] aR, bR, cR;
  logic             v1R;
  logic [WIDTH-1:0] votedS;
  logic [2:0]       disagreeS;
  runCnt_t          runCntR [NUM_REP];
  runCnt_t          runCntS [NUM_REP];
  logic [2:0]       faultHitS;

  // stage 1: capture replica words; data holds while no sample is offered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aR  <= '0;
      bR  <= '0;
      cR  <= '0;
      v1R <= 1'b0;
    end else if (valid_i) begin
      aR  <= inA;
      bR  <= inB;
      cR  <= inC;
      v1R <= 1'b1;
    end else begin
      v1R <= 1'b0;
    end
  end

  majority_voter #(.WIDTH(WIDTH)) uVoter (
    .inA      (aR),
    .inB      (bR),
    .inC      (cR),
    .voted    (votedS),
    .disagree (disagreeS)
  );

  // next run counts; clear suppresses both the increment and the fault hit
  always_comb begin
    for (int i = 0; i < NUM_REP; i++) begin
      runCntS[i]   = runCntR[i];
      faultHitS[i] = 1'b0;
      if (clear_i) begin
        runCntS[i] = '0;
      end else if (v1R) begin
        if (!disagreeS[i]) begin
          runCntS[i] = '0;
        end else if (runCntR[i] < THRESH) begin
          runCntS[i] = runCntR[i] + RUN_CNT_W'(1);
        end else begin
          runCntS[i] = runCntR[i];
        end
        faultHitS[i] = (runCntS[i] == THRESH);
      end else begin
        runCntS[i] = runCntR[i];
      end
    end
  end

  // stage 2: voted output, error pulse, run counters and sticky faults
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_o   <= '0;
      valid_o <= 1'b0;
      err_o   <= 1'b0;
      fault_o <= 3'b000;
      for (int i = 0; i < NUM_REP; i++) begin
        runCntR[i] <= '0;
      end
    end else begin
      valid_o <= v1R;
      err_o   <= v1R & (|disagreeS);
      if (v1R) begin
        out_o <= votedS;
      end else begin
        out_o <= out_o;
      end
      if (clear_i) begin
        fault_o <= 3'b000;
      end else begin
        fault_o <= fault_o | faultHitS;
      end
      for (int i = 0; i < NUM_REP; i++) begin
        runCntR[i] <= runCntS[i];
      end
    end
  end

`ifdef TMR_VOTE_ERRCNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  logic [CNT_WIDTH-1:0] errCntR;

  // saturating count of erroneous samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      errCntR <= '0;
    end else if (clear_i) begin
      errCntR <= '0;
    end else if (v1R && (|disagreeS) && (errCntR != CNT_MAX)) begin
      errCntR <= errCntR + CNT_WIDTH'(1);
    end else begin
      errCntR <= errCntR;
    end
  end

  assign err_count_o = errCntR;
`else
  assign err_count_o = '0;
`endif

endmodule

// File: tb/tb_tmr_vote_reg.sv
// Randomised bench for tmr_vote_reg with a behavioural reference model,
// directed scenarios pinned by literal expectations.
module tb_tmr_vote_reg;

`ifdef TMR_VOTE_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam int TH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rstChk = 1'b0;
  logic [7:0] inA = 8'h00, inB = 8'h00, inC = 8'h00;
  logic       validI = 1'b0, clearI = 1'b0;

  logic [7:0]  out1, out2;
  logic        valid1, valid2, err1, err2;
  logic [2:0]  fault1, fault2;
  logic [15:0] cnt1;
  logic [1:0]  cnt2;

  always #5 clk = ~clk;

  tmr_vote_reg dut (
    .clk(clk), .rst(rst), .inA(inA), .inB(inB), .inC(inC),
    .valid_i(validI), .clear_i(clearI), .out_o(out1), .valid_o(valid1),
    .err_o(err1), .fault_o(fault1), .err_count_o(cnt1)
  );

  tmr_vote_reg #(.CNT_WIDTH(2)) dutSat (
    .clk(clk), .rst(rst), .inA(inA), .inB(inB), .inC(inC),
    .valid_i(validI), .clear_i(clearI), .out_o(out2), .valid_o(valid2),
    .err_o(err2), .fault_o(fault2), .err_count_o(cnt2)
  );

  // reference model state
  logic [7:0] mA, mB, mC, mOut;
  bit         mV, mValid, mErr;
  bit   [2:0] mFault;
  int         mRun [3];
  int         mCnt, mCnt2;

  int pinOut, pinValid, pinErr, pinFault, pinCnt, pinCnt2;
  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] vote(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = (int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2;
    return r;
  endfunction

  task automatic pinsOff();
    pinOut = -1; pinValid = -1; pinErr = -1; pinFault = -1; pinCnt = -1; pinCnt2 = -1;
  endtask

  task automatic modelReset();
    mA = 8'h00; mB = 8'h00; mC = 8'h00; mOut = 8'h00;
    mV = 1'b0; mValid = 1'b0; mErr = 1'b0; mFault = 3'b000;
    for (int i = 0; i < 3; i++) mRun[i] = 0;
    mCnt = 0; mCnt2 = 0;
  endtask

  task automatic modelEdge();
    logic [7:0] v;
    bit   [2:0] d;
    if (rst) begin
      modelReset();
    end else begin
      if (mV) begin
        v = vote(mA, mB, mC);
        d = {mC != v, mB != v, mA != v};
        mOut = v;
        mErr = (d != 3'b000);
        for (int i = 0; i < 3; i++) begin
          if (!d[i]) mRun[i] = 0;
          else begin
            mRun[i] = (mRun[i] + 1 > TH) ? TH : mRun[i] + 1;
            if (mRun[i] == TH) mFault[i] = 1'b1;
          end
        end
        if (d != 3'b000 && CNT_EN) begin
          if (mCnt < 65535) mCnt++;
          if (mCnt2 < 3) mCnt2++;
        end
      end else begin
        mErr = 1'b0;
      end
      mValid = mV;
      if (clearI) begin
        mFault = 3'b000; mCnt = 0; mCnt2 = 0;
        for (int i = 0; i < 3; i++) mRun[i] = 0;
      end
      if (validI) begin
        mA = inA; mB = inB; mC = inC; mV = 1'b1;
      end else begin
        mV = 1'b0;
      end
    end
  endtask

  task automatic cycle(input bit v, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input bit clr);
    validI = v; inA = a; inB = b; inC = c; clearI = clr;
    @(posedge clk);
    modelEdge();
    pinsOff();
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // compare DUTs against the model every cycle, plus literal pins when set
  always @(negedge clk or posedge rstChk) begin
    chk("out_o", 32'(out1), 32'(mOut));
    chk("valid_o", 32'(valid1), 32'(mValid));
    chk("err_o", 32'(err1), 32'(mErr));
    chk("fault_o", 32'(fault1), 32'(mFault));
    chk("err_count_o", 32'(cnt1), 32'(mCnt));
    chk("sat.out_o", 32'(out2), 32'(mOut));
    chk("sat.valid_o", 32'(valid2), 32'(mValid));
    chk("sat.err_o", 32'(err2), 32'(mErr));
    chk("sat.fault_o", 32'(fault2), 32'(mFault));
    chk("sat.err_count_o", 32'(cnt2), 32'(mCnt2));
    if (pinOut >= 0) begin chk("pin out", 32'(out1), pinOut); chk("pin model out", 32'(mOut), pinOut); end
    if (pinValid >= 0) begin chk("pin valid", 32'(valid1), pinValid); chk("pin model valid", 32'(mValid), pinValid); end
    if (pinErr >= 0) begin chk("pin err", 32'(err1), pinErr); chk("pin model err", 32'(mErr), pinErr); end
    if (pinFault >= 0) begin chk("pin fault", 32'(fault1), pinFault); chk("pin model fault", 32'(mFault), pinFault); end
    if (pinCnt >= 0) begin chk("pin cnt", 32'(cnt1), pinCnt); chk("pin model cnt", 32'(mCnt), pinCnt); end
    if (pinCnt2 >= 0) begin chk("pin sat cnt", 32'(cnt2), pinCnt2); chk("pin model sat cnt", 32'(mCnt2), pinCnt2); end
  end

  initial begin
    logic [7:0] base, a, b, c, m;
    int r, bad;
    pinsOff();
    modelReset();
    #2;
    cycle(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    rst = 1'b0;
    pinOut = 0; pinValid = 0; pinErr = 0; pinFault = 0; pinCnt = 0; pinCnt2 = 0;

    // clean samples
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'h5A, 8'h5A, 8'h5A, 1'b0);
    pinOut = 8'h5A; pinValid = 1; pinErr = 0; pinFault = 0; pinCnt = 0;

    // single upset on B
    cycle(1'b1, 8'h5A, 8'h5B, 8'h5A, 1'b0);
    cycle(1'b0, 8'h5A, 8'h5A, 8'h5A, 1'b0);
    pinOut = 8'h5A; pinErr = 1; pinFault = 0; pinCnt = CNT_EN ? 1 : 0; pinCnt2 = CNT_EN ? 1 : 0;
    cycle(1'b0, 8'h5A, 8'h5A, 8'h5A, 1'b0);
    pinErr = 0; pinValid = 0;

    // persistent fault on C
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h00, 8'h00, 8'hFF, 1'b0);
    pinFault = 0; pinErr = 1;
    cycle(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    pinFault = 3'b100; pinErr = 1; pinOut = 0;
    cycle(1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    pinFault = 3'b100; pinErr = 0; pinCnt = CNT_EN ? 5 : 0; pinCnt2 = CNT_EN ? 3 : 0;

    // clear, then interrupted runs on A with gaps
    cycle(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    pinFault = 0; pinCnt = 0; pinCnt2 = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 8'h01, 8'h00, 8'h00, 1'b0);
      cycle(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    end
    cycle(1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 8'h01, 8'h00, 8'h00, 1'b0);
      cycle(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    end
    cycle(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    pinFault = 0; pinCnt = CNT_EN ? 6 : 0; pinCnt2 = CNT_EN ? 3 : 0;

    // clear priority over a same-edge erroneous sample
    cycle(1'b1, 8'h00, 8'hFF, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    pinCnt = CNT_EN ? 7 : 0; pinFault = 0;
    cycle(1'b1, 8'h00, 8'h00, 8'h0F, 1'b0);
    cycle(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    pinErr = 1; pinValid = 1; pinOut = 0; pinCnt = 0; pinCnt2 = 0; pinFault = 0;
    cycle(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    pinErr = 0; pinValid = 0;

    // async reset mid-stream
    cycle(1'b1, 8'h77, 8'h77, 8'h70, 1'b0);
    cycle(1'b1, 8'h77, 8'h77, 8'h70, 1'b0);
    rst = 1'b1;
    modelReset();
    pinOut = 0; pinValid = 0; pinErr = 0; pinFault = 0; pinCnt = 0; pinCnt2 = 0;
    #1 rstChk = 1'b1;
    #1 rstChk = 1'b0;
    cycle(1'b1, 8'h11, 8'h11, 8'h11, 1'b0);
    rst = 1'b0;
    cycle(1'b1, 8'h33, 8'h33, 8'h33, 1'b0);
    pinValid = 0;
    cycle(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    pinValid = 1; pinOut = 8'h33; pinErr = 0;

    // randomised traffic biased toward a recurring bad replica
    bad = 2;
    for (int n = 0; n < 1500; n++) begin
      base = 8'($urandom);
      a = base; b = base; c = base;
      m = 8'($urandom_range(1, 255));
      r = $urandom_range(0, 9);
      if (r >= 3 && r <= 4) begin
        case ($urandom_range(0, 2))
          0: a = a ^ m;
          1: b = b ^ m;
          default: c = c ^ m;
        endcase
      end else if (r == 5) begin
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
      end else if (r >= 6) begin
        case (bad)
          0: a = a ^ m;
          1: b = b ^ m;
          default: c = c ^ m;
        endcase
      end
      if ($urandom_range(0, 49) == 0) bad = $urandom_range(0, 2);
      cycle($urandom_range(0, 3) != 0, a, b, c, $urandom_range(0, 39) == 0);
    end
    cycle(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmr_vote_reg.md
# tmr_vote_reg

Registered majority-voting stage that consumes the three replica outputs of a triplicated logic block (A/B/C domains fed by `fanout`) and collapses them into one voted word. It runs a two-stage pipeline, flags single-sample disagreements, and declares a replica faulty after a run of consecutive disagreements. An optional saturating error counter supports SEU-rate monitoring. It sits at the TMR-to-non-TMR boundary, directly after the triplicated combinational logic.

## Interface
- `WIDTH`, 8: bits per replica word.
- `FAULT_THRESH`, 4: consecutive disagreeing valid samples before a replica is declared faulty (1..15).
- `CNT_WIDTH`, 16: width of the error counter.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `inA`, `inB`, `inC`  in  WIDTH  replica words.
- `valid_i`  in  1  the three replica words are valid this cycle.
- `clear_i`  in  1  clears `fault_o` and `err_count_o`.
- `out_o`  out  WIDTH  voted word.
- `valid_o`  out  1  `out_o` is valid.
- `err_o`  out  1  one-cycle pulse with `valid_o` when any replica disagreed on that sample.
- `fault_o`  out  3  sticky per-replica fault flags; bit 0 = A, bit 1 = B, bit 2 = C.
- `err_count_o`  out  CNT_WIDTH  saturating count of erroneous samples (only with the counter macro).

## Operation
- **Stage 1:** when `valid_i` = 1, register `inA`/`inB`/`inC` and set `v1` = 1. Otherwise `v1` = 0 and the data registers hold.
- **Stage 2, voting:** when `v1` = 1, the voted word is the bitwise majority (A&B | A&C | B&C), registered into `out_o`. `valid_o` follows `v1`.
- **Disagreement:** replica X disagrees when X differs from the voted word in any bit. `err_o` = OR of the three disagree bits, registered alongside `out_o`.
- **Per-replica run counters:** one counter per replica, width 4.
  - On a valid sample where the replica disagrees: increment, saturating at `FAULT_THRESH`.
  - On a valid sample where the replica agrees: reset to 0.
  - Non-valid cycles: hold.
- **Fault flag:** `fault_o[X]` sets in the cycle the run counter reaches `FAULT_THRESH`. It is sticky until `clear_i` or `rst`.
- **Clear:** `clear_i` zeroes `fault_o`, the run counters and `err_count_o` on the next edge.
  - Clear wins over a same-cycle set or increment: the sample is not counted and no fault bit is set.
  - `out_o`, `valid_o` and `err_o` are unaffected by `clear_i`.
- **No-majority bits:** when all three replicas differ at some bit, the bitwise majority still applies. Every replica that differs from the result is flagged. There is no separate uncorrectable indication.
- **Faulty replicas:** a faulty replica still participates in voting. Exclusion is the job of downstream logic.

## Timing
- Latency is 2 cycles: a sample accepted at edge N appears on `out_o` / `valid_o` / `err_o` after edge N+1.
- Throughput is one sample per cycle. There is no backpressure; the consumer must accept every `valid_o`.
- `fault_o` updates at the same edge as the `err_o` of the sample that crossed the threshold.
- **Reset (asynchronous, immediate):** `out_o` = 0, `valid_o` = 0, `err_o` = 0, `fault_o` = 3'b000, `err_count_o` = 0, all run counters = 0, `v1` = 0.
- **Reset mid-stream:** samples in flight are dropped. The first valid output after release appears two edges after the first accepted `valid_i`.

## Configuration
- `TMR_VOTE_ERRCNT_EN` defined:
  - `err_count_o` increments on every valid erroneous sample.
  - It saturates at 2^CNT_WIDTH−1 and never wraps.
  - It clears on `clear_i` or `rst`.
- Macro undefined: the counter register is not built and `err_count_o` is tied to 0. The port remains so the instantiation is the same in both builds.

## Structure
- Shared package `tmr_vote_pkg` holds:
  - replica index constants `REP_A` = 0, `REP_B` = 1, `REP_C` = 2;
  - `RUN_CNT_W` = 4;
  - a `majority3` function for use in checker code.
- One sub-module, `majority_voter`: parameterised WIDTH, purely combinational. Outputs are the voted word and a 3-bit disagree vector. This keeps the vote logic reusable by other TMR boundary stages.

## Test plan
- **Clean samples:** `inA` = `inB` = `inC` = 8'h5A with `valid_i` for 10 cycles → `out_o` = 8'h5A two edges after each input, `err_o` = 0, `fault_o` = 0, `err_count_o` = 0.
- **Single upset:** one sample with `inB` = 8'h5B, the others 8'h5A → `out_o` = 8'h5A, `err_o` = 1 for one cycle, `err_count_o` = 1, `fault_o` = 0.
- **Persistent fault:** `inC` = 8'hFF, the others 8'h00, for 4 consecutive valid samples → `fault_o` = 3'b100 at the `valid_o` of sample 4. It stays set after `inC` returns to 8'h00.
- **Run reset and gaps:** `inA` disagrees for 3 samples, then agrees once, then disagrees for 3 more, with `valid_i` = 0 gaps interleaved → `fault_o[0]` never sets.
- **Clear priority:** `clear_i` asserted on the same edge as an erroneous sample reaches stage 2, with `err_count_o` = 7 → `err_count_o` = 0, `fault_o` = 0, and `err_o` still pulses.
- **Async reset and saturation:** assert `rst` mid-stream → all outputs are 0 immediately. Separately, with `CNT_WIDTH` = 2 and 5 erroneous samples → `err_count_o` holds at 3.
